// File: rtl/rtr_op_packet_arb_if.sv
// Request/grant bundle between the input-port route filters and one output-port arbiter.
// master = requester side (filters, downstream credit), slave = arbiter.
interface rtr_op_packet_arb_if #(
   parameter int unsigned num_ports = 5
);
   logic [0:num_ports-1] req_valid;
   logic [0:num_ports-1] req_head;
   logic [0:num_ports-1] req_tail;
   logic                 out_ready;
   logic [0:num_ports-1] gnt;
   logic                 gnt_valid;
   logic                 busy;
   logic [0:1]           errors;

   modport master (
      output req_valid, req_head, req_tail, out_ready,
      input  gnt, gnt_valid, busy, errors
   );

   modport slave (
      input  req_valid, req_head, req_tail, out_ready,
      output gnt, gnt_valid, busy, errors
   );
endinterface

// File: rtl/rtr_op_packet_arb.sv
// Per-output-port packet arbiter: round-robin head selection, grant held from head to tail.
// Optional stalled-owner watchdog enabled by defining RTR_OP_ARB_WATCHDOG_EN.
module rtr_op_packet_arb #(
   parameter int unsigned num_ports = 5,
   parameter int unsigned port_id   = 0,
   parameter int unsigned wd_limit  = 255
) (
   input logic                clk,
   input logic                reset_n,
   rtr_op_packet_arb_if.slave bus
);
   localparam int unsigned PtrW = (num_ports > 2) ? $clog2(num_ports) : 1;
   localparam logic StIdle   = 1'b0;
   localparam logic StLocked = 1'b1;

   if (num_ports < 2 || port_id >= num_ports || wd_limit < 1 || wd_limit > 65535) begin : g_bad_cfg
      $error("rtr_op_packet_arb: parameter out of range");
   end

   logic                 state_q, state_d;
   logic [PtrW-1:0]      rr_ptr_q, rr_ptr_d;
   logic [PtrW-1:0]      owner_q, owner_d;
   logic                 perr_q, perr_d;
   logic                 wderr;
   logic [PtrW-1:0]      win;
   logic                 found;
   logic [0:num_ports-1] cand;
   logic [0:num_ports-1] gnt_raw;
   logic                 xfer;

   function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
      return (p == PtrW'(num_ports - 1)) ? '0 : p + 1'b1;
   endfunction

   assign cand = bus.req_valid & bus.req_head;

   // First candidate at or after rr_ptr, wrapping.
   always_comb begin
      int idx;
      idx   = 0;
      found = 1'b0;
      win   = '0;
      for (int k = 0; k < int'(num_ports); k++) begin
         idx = (int'(rr_ptr_q) + k) % int'(num_ports);
         if (!found && cand[idx]) begin
            found = 1'b1;
            win   = PtrW'(idx);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      owner_d  = owner_q;
      perr_d   = perr_q;
      gnt_raw  = '0;
      unique case (state_q)
         StIdle: begin
            if ((|(bus.req_valid & ~bus.req_head)) || bus.req_valid[port_id]) perr_d = 1'b1;
            if (found && bus.out_ready) begin
               gnt_raw[win] = 1'b1;
               if (bus.req_tail[win]) begin
                  rr_ptr_d = next_ptr(win);
               end else begin
                  state_d = StLocked;
                  owner_d = win;
               end
            end
         end
         StLocked: begin
            if (bus.req_valid[owner_q] && bus.out_ready) begin
               gnt_raw[owner_q] = 1'b1;
               if (bus.req_head[owner_q]) perr_d = 1'b1;
               // Tail releases the lock; a waiting head is only seen next cycle in IDLE.
               if (bus.req_tail[owner_q]) begin
                  state_d  = StIdle;
                  rr_ptr_d = next_ptr(owner_q);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign xfer = |gnt_raw;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         rr_ptr_q <= '0;
         owner_q  <= '0;
         perr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
         perr_q   <= perr_d;
      end
   end

`ifdef RTR_OP_ARB_WATCHDOG_EN
   localparam logic [15:0] WdLimit = 16'(wd_limit);

   logic [15:0] wd_cnt_q, wd_cnt_d;
   logic        wderr_q, wderr_d;

   always_comb begin
      wd_cnt_d = wd_cnt_q;
      if (state_q == StIdle || xfer) begin
         wd_cnt_d = '0;
      end else if (wd_cnt_q < WdLimit) begin
         wd_cnt_d = wd_cnt_q + 16'd1;
      end
      wderr_d = wderr_q | (wd_cnt_d == WdLimit);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wd_cnt_q <= '0;
         wderr_q  <= 1'b0;
      end else begin
         wd_cnt_q <= wd_cnt_d;
         wderr_q  <= wderr_d;
      end
   end

   assign wderr = wderr_q;
`else
   assign wderr = 1'b0;
`endif

   // IDLE grants are purely combinational, so gate them while reset is held.
   assign bus.gnt       = reset_n ? gnt_raw : '0;
   assign bus.gnt_valid = reset_n & xfer;
   assign bus.busy      = (state_q == StLocked);
   assign bus.errors    = {perr_q, wderr};

endmodule

// File: doc/rtr_op_packet_arb.md
Name: rtr_op_packet_arb

Overview:
- Per-output-port packet-level arbiter; one instance per router output port.
- Sits downstream of the per-input-VC route filters.
- Takes filtered, head-of-line requests from all input ports targeting this output and grants one input at a time, round-robin.
- Holds the grant for the whole packet (head to tail), stalls while downstream credit is absent, and flags protocol violations.

Parameters:
- num_ports, 5: number of router input ports (requesters); minimum 2.
- port_id, 0: ID of the output port this instance controls.
- wd_limit, 255: watchdog threshold in cycles; 1..65535; counter is 16 bits.

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- req_valid  input  [0:num_ports-1]  input i presents a flit whose filtered route selects this output
- req_head  input  [0:num_ports-1]  flit presented by input i is a head flit
- req_tail  input  [0:num_ports-1]  flit presented by input i is a tail flit (head+tail = single-flit packet)
- out_ready  input  1  downstream credit available this cycle
- gnt  output  [0:num_ports-1]  one-hot; flit from input i transfers this cycle
- gnt_valid  output  1  OR of gnt
- busy  output  1  arbiter locked to a packet owner
- errors  output  [0:1]  [0]=protocol error, [1]=watchdog error

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE, rr_ptr=0, owner=0, wd_cnt=0, errors=2'b00.
  - gnt, gnt_valid and busy are 0 while reset_n is low.
- gnt is combinational from the current state and inputs (zero-cycle grant latency); all state updates on posedge clk.
- State IDLE (busy=0):
  - Candidates = req_valid & req_head.
  - Winner = first set candidate scanning rr_ptr, rr_ptr+1, ... mod num_ports.
  - If out_ready=1 and a winner exists: gnt[winner]=1.
    - Winner's req_tail=1: stay IDLE, rr_ptr <= (winner+1) mod num_ports.
    - Winner's req_tail=0: go LOCKED, owner <= winner.
  - out_ready=0: gnt=0; no state or rr_ptr change. Selection is re-evaluated every cycle; no pre-locking.
- State LOCKED (busy=1):
  - gnt[owner] = req_valid[owner] & out_ready. Requests from other inputs are ignored.
  - Transfer with req_tail[owner]=1: go IDLE, rr_ptr <= (owner+1) mod num_ports.
  - Transfer with req_head[owner]=1 (new head before tail): set errors[0]. Flit still transfers; state follows the tail bit.
- rr_ptr wraps from num_ports-1 to 0.
- Simultaneous tail-out and new head: the new head is not granted in the tail cycle; it is granted earliest the next cycle (one IDLE cycle minimum between multi-flit packets).
- Protocol error, errors[0]: also set in IDLE if any req_valid[i] & ~req_head[i], or if req_valid[port_id] is set.
- Watchdog:
  - wd_cnt increments each cycle in LOCKED with no transfer.
  - wd_cnt clears on any transfer and in IDLE.
  - wd_cnt saturates at wd_limit; reaching wd_limit sets errors[1].
- errors bits are sticky; cleared only by reset. They are registered, so visible one cycle after the cause.
- Reset mid-packet: the packet is abandoned, the arbiter returns to IDLE, and the next head is arbitrated from rr_ptr=0.

Optional Feature:
- Macro: RTR_OP_ARB_WATCHDOG_EN.
- Defined: wd_cnt is implemented and errors[1] behaves as above.
- Undefined: no counter logic; errors[1] tied to 0; wd_limit unused.

Test Plan:
- Reset, then req_valid=5'b01010 with heads, tails=1, out_ready=1 -> gnt=01000, then 00010, then 01000; rr_ptr sequence 2,4,2.
- Input 2 sends a 3-flit packet; input 0 requests from cycle 1 -> gnt=00100 for 3 transfer cycles, busy=1; after the tail, one idle cycle, then gnt=10000.
- LOCKED owner 1 with out_ready toggling 1,0,0,1 -> gnt=01000 only on ready cycles; state is held and no other input is granted.
- Owner presents req_head=1 mid-packet -> errors=2'b10 from the next cycle and stays set until reset_n is pulsed.
- Macro defined, wd_limit=4, owner valid=0 for 4 cycles -> errors[1]=1 on cycle 5; macro undefined -> errors[1] stays 0.
- Assert reset_n=0 during LOCKED -> gnt=0 and busy=0 immediately (asynchronous); after release, head on input 4 only -> gnt=00001.
